// File: rtl/lbm_moment_engine.sv
// D2Q9 macroscopic-moment engine: sweeps every cell computing rho, ux, uy, or writes the rest-state lattice.
// Latency: init sweep 1 cycle/cell; moment sweep DW+FB+4 cycles/cell (5 when rho <= 0); done one cycle after the last write.
// Backpressure: none; start is honoured only in IDLE, RAMs are assumed to accept a write every cycle.
// Ports: start/mode request a sweep; busy/done/div_err report status; address drives all RAMs;
//        fin_rdata in (lane 0 MSBs, 1-cycle read); fin_we/fin_wdata, {rho,ux,uy}_we/_wdata out.
module lbm_moment_engine #(
    parameter int GRID_DIM        = 256,
    parameter int DATA_WIDTH      = 32,
    parameter int FRACTIONAL_BITS = 24,
    parameter int ADDRESS_WIDTH   = $clog2(GRID_DIM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mode,
    output logic                      busy,
    output logic                      done,
    output logic                      div_err,
    output logic [ADDRESS_WIDTH-1:0]  address,
    input  logic [9*DATA_WIDTH-1:0]   fin_rdata,
    output logic                      fin_we,
    output logic [9*DATA_WIDTH-1:0]   fin_wdata,
    output logic                      rho_we,
    output logic                      ux_we,
    output logic                      uy_we,
    output logic [DATA_WIDTH-1:0]     rho_wdata,
    output logic [DATA_WIDTH-1:0]     ux_wdata,
    output logic [DATA_WIDTH-1:0]     uy_wdata
);
    localparam int DW = DATA_WIDTH;
    localparam int SW = DATA_WIDTH + 4;
    localparam int QW = DATA_WIDTH + FRACTIONAL_BITS;
    localparam int CW = $clog2(QW + 1);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(GRID_DIM - 1);
    localparam logic [DW-1:0] ONE = DW'(64'd1 << FRACTIONAL_BITS);
    localparam logic [DW-1:0] W_C = DW'((64'd4 << FRACTIONAL_BITS) / 64'd9);
    localparam logic [DW-1:0] W_A = DW'((64'd1 << FRACTIONAL_BITS) / 64'd9);
    localparam logic [DW-1:0] W_D = DW'((64'd1 << FRACTIONAL_BITS) / 64'd36);
    localparam logic [DW-1:0] MAX_W = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_W = {1'b1, {(DW-1){1'b0}}};
    localparam logic [QW-1:0] MAG_POS = QW'(MAX_W);
    localparam logic [QW-1:0] MAG_NEG = QW'(MIN_W);

    // Lattice velocity signs, bit i = lane i.
    localparam logic [8:0] CX_POS = 9'b100100010;
    localparam logic [8:0] CX_NEG = 9'b011001000;
    localparam logic [8:0] CY_POS = 9'b001100100;
    localparam logic [8:0] CY_NEG = 9'b110010000;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RD, S_CAP, S_SUM, S_DIV, S_WR, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [9*DW-1:0]            f_q, f_d;
    logic [DW-1:0]              rho_q, rho_d;
    logic                       bad_q, bad_d;
    logic                       div_err_q, div_err_d;
    logic [1:0]                 neg_q, neg_d;
    logic [1:0][DW-1:0]         rem_q, rem_d;
    logic [1:0][QW-1:0]         quo_q, quo_d;

    logic signed [DW-1:0]       lane;
    logic signed [SW-1:0]       s_rho, s_x, s_y;
    logic [DW-1:0]              rho_sat, x_sat, y_sat;
    logic [DW:0]                rs;

    function automatic logic [DW-1:0] sat_word(input logic signed [SW-1:0] s);
        if ((&s[SW-1:DW-1]) || !(|s[SW-1:DW-1])) return s[DW-1:0];
        else if (s[SW-1])                         return MIN_W;
        else                                      return MAX_W;
    endfunction

    function automatic logic [DW-1:0] abs_word(input logic [DW-1:0] v);
        return v[DW-1] ? -v : v;
    endfunction

    // Quotient magnitude back to a signed word, clamping on overflow.
    function automatic logic [DW-1:0] signed_quot(input logic [QW-1:0] mag, input logic neg);
        if (neg) return (mag > MAG_NEG) ? MIN_W : -mag[DW-1:0];
        else     return (mag > MAG_POS) ? MAX_W :  mag[DW-1:0];
    endfunction

    // Velocities are 0/+-1, so the weighted sums are plain add/subtract trees.
    always_comb begin
        s_rho = '0;
        s_x   = '0;
        s_y   = '0;
        lane  = '0;
        for (int i = 0; i < 9; i++) begin
            lane  = f_q[(8-i)*DW +: DW];
            s_rho = s_rho + SW'(lane);
            if (CX_POS[i])      s_x = s_x + SW'(lane);
            else if (CX_NEG[i]) s_x = s_x - SW'(lane);
            if (CY_POS[i])      s_y = s_y + SW'(lane);
            else if (CY_NEG[i]) s_y = s_y - SW'(lane);
        end
        rho_sat = sat_word(s_rho);
        x_sat   = sat_word(s_x);
        y_sat   = sat_word(s_y);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        f_d       = f_q;
        rho_d     = rho_q;
        bad_d     = bad_q;
        div_err_d = div_err_q;
        neg_d     = neg_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        rs        = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_err_d = 1'b0;
                    addr_d    = '0;
                    state_d   = mode ? S_INIT : S_RD;
                end
            end
            S_INIT: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_DONE;
                end else begin
                    addr_d = addr_q + ADDRESS_WIDTH'(1);
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                f_d     = fin_rdata;
                state_d = S_SUM;
            end
            S_SUM: begin
                // Dividers are loaded straight from the saturated sums so DIV starts iterating at once.
                rho_d    = rho_sat;
                bad_d    = rho_sat[DW-1] || (rho_sat == '0);
                if (rho_sat[DW-1] || (rho_sat == '0)) div_err_d = 1'b1;
                neg_d    = {y_sat[DW-1], x_sat[DW-1]};
                quo_d[0] = {abs_word(x_sat), {FRACTIONAL_BITS{1'b0}}};
                quo_d[1] = {abs_word(y_sat), {FRACTIONAL_BITS{1'b0}}};
                rem_d    = '0;
                cnt_d    = '0;
                state_d  = S_DIV;
            end
            S_DIV: begin
                if (bad_q) begin
                    state_d = S_WR;
                end else begin
                    // One restoring step per cycle; rho_q is known positive here.
                    for (int i = 0; i < 2; i++) begin
                        rs = {rem_q[i], quo_q[i][QW-1]};
                        if (rs >= {1'b0, rho_q}) begin
                            rem_d[i] = DW'(rs - {1'b0, rho_q});
                            quo_d[i] = {quo_q[i][QW-2:0], 1'b1};
                        end else begin
                            rem_d[i] = rs[DW-1:0];
                            quo_d[i] = {quo_q[i][QW-2:0], 1'b0};
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(QW - 1)) state_d = S_WR;
                end
            end
            S_WR: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDRESS_WIDTH'(1);
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            f_q       <= '0;
            rho_q     <= '0;
            bad_q     <= 1'b0;
            div_err_q <= 1'b0;
            neg_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            f_q       <= f_d;
            rho_q     <= rho_d;
            bad_q     <= bad_d;
            div_err_q <= div_err_d;
            neg_q     <= neg_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
        end
    end

    // Outputs decode from state so an asynchronous reset silences all writes immediately.
    always_comb begin
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        div_err   = div_err_q;
        address   = addr_q;
        fin_we    = (state_q == S_INIT);
        rho_we    = (state_q == S_INIT) || (state_q == S_WR);
        ux_we     = rho_we;
        uy_we     = rho_we;
        rho_wdata = '0;
        ux_wdata  = '0;
        uy_wdata  = '0;
        if (state_q == S_INIT) begin
            rho_wdata = ONE;
        end else if (state_q == S_WR) begin
            rho_wdata = rho_q;
            if (!bad_q) begin
                ux_wdata = signed_quot(quo_q[0], neg_q[0]);
                uy_wdata = signed_quot(quo_q[1], neg_q[1]);
            end
        end
    end

    assign fin_wdata = {W_C, {4{W_A}}, {4{W_D}}};

endmodule
